// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR sequencer:
// FSM state encoding, default coefficient table and width helpers.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MAC  = 2'd2,
      OUT  = 2'd3
   } fir_state_t;

   // First half of the symmetric low-pass default; the second half mirrors it.
   localparam int DEF_HALF_LEN = 8;
   localparam int DEF_HALF [DEF_HALF_LEN] = '{311, 469, 917, 1582, 2352, 3091, 3671, 3990};

   function automatic int default_coef(input int k, input int n);
      int m;
      m = (k < n / 2) ? k : (n - 1 - k);
      return DEF_HALF[m % DEF_HALF_LEN];
   endfunction

   // Select/index width that never collapses to zero bits.
   function automatic int sel_width(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// Per-channel sample history: CH*N entries addressed by {channel, pointer},
// one synchronous write port, one combinational read port, cleared on reset.
module fir_hist_ram
   import fir_pkg::*;
#(
   parameter int N     = 16,
   parameter int WIDTH = 14,
   parameter int CH    = 2,
   parameter int NW    = $clog2(N),
   parameter int CHW   = sel_width(CH)
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    we_i,
   input  logic [CHW-1:0]          wr_ch_i,
   input  logic [NW-1:0]           wr_ptr_i,
   input  logic signed [WIDTH-1:0] wr_data_i,
   input  logic [CHW-1:0]          rd_ch_i,
   input  logic [NW-1:0]           rd_ptr_i,
   output logic signed [WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = CH * N;
   localparam int AW    = $clog2(DEPTH);

   logic signed [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]           wr_addr;
   logic [AW-1:0]           rd_addr;

   // With a single channel the channel bit carries no information and is dropped.
   assign wr_addr   = AW'({wr_ch_i, wr_ptr_i});
   assign rd_addr   = AW'({rd_ch_i, rd_ptr_i});
   assign rd_data_o = mem_q[rd_addr];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[wr_addr] <= wr_data_i;
      end
   end

endmodule

// File: rtl/fir_tdm_sequencer.sv
// Time-multiplexed FIR: one signed MAC shared across CH channels and N taps,
// with per-channel circular history and a double-buffered coefficient bank.
module fir_tdm_sequencer
   import fir_pkg::*;
#(
   parameter int N     = 16,
   parameter int WIDTH = 14,
   parameter int CW    = 16,
   parameter int CH    = 2,
   parameter int OUTW  = WIDTH + CW + $clog2(N)
) (
   input  logic                              clk,
   input  logic                              n_rst,
   input  logic                              din_valid_i,
   input  logic [sel_width(CH)-1:0]          din_ch_i,
   input  logic signed [WIDTH-1:0]           din_i,
   output logic                              din_ready_o,
   input  logic                              coef_we_i,
   input  logic [$clog2(N)-1:0]              coef_addr_i,
   input  logic signed [CW-1:0]              coef_data_i,
   input  logic                              coef_commit_i,
   output logic                              dout_valid_o,
   output logic [sel_width(CH)-1:0]          dout_ch_o,
   output logic signed [OUTW-1:0]            dout_o,
   output logic                              busy_o,
   output logic                              overrun_o,
   output fir_state_t                        dbg_state_o
);

   localparam int NW  = $clog2(N);
   localparam int CHW = sel_width(CH);
   localparam int PW  = WIDTH + CW;
   localparam logic [NW-1:0] K_LAST = NW'(N - 1);

   fir_state_t              state_q;
   logic [CHW-1:0]          ch_q;
   logic signed [WIDTH-1:0] sample_q;
   logic [NW-1:0]           k_q;
   logic signed [OUTW-1:0]  acc_q;
   logic [NW-1:0]           wptr_q [CH];
   logic                    dout_valid_q;
   logic [CHW-1:0]          dout_ch_q;
   logic signed [OUTW-1:0]  dout_q;
   logic                    overrun_q;

   logic signed [CW-1:0]    shadow_q [N];
   logic signed [CW-1:0]    shadow_d [N];
   logic signed [CW-1:0]    active_q [N];
   logic                    pending_q;
   logic                    pending_d;
   logic                    commit_now;

   logic signed [WIDTH-1:0] hist_rd;
   logic [NW-1:0]           rd_ptr;
   logic signed [PW-1:0]    prod;
   logic signed [OUTW-1:0]  acc_next;

   assign din_ready_o  = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign dout_valid_o = dout_valid_q;
   assign dout_ch_o    = dout_ch_q;
   assign dout_o       = dout_q;
   assign overrun_o    = overrun_q;
   assign dbg_state_o  = state_q;

   // Tap k reads the sample k steps older than the newest; pointer wraps mod N.
   assign rd_ptr   = wptr_q[ch_q] - k_q;
   assign prod     = hist_rd * active_q[k_q];
   assign acc_next = acc_q + {{(OUTW - PW){prod[PW-1]}}, prod};

   fir_hist_ram #(
      .N     (N),
      .WIDTH (WIDTH),
      .CH    (CH),
      .NW    (NW),
      .CHW   (CHW)
   ) u_hist (
      .clk       (clk),
      .n_rst     (n_rst),
      .we_i      (state_q == LOAD),
      .wr_ch_i   (ch_q),
      .wr_ptr_i  (wptr_q[ch_q]),
      .wr_data_i (sample_q),
      .rd_ch_i   (ch_q),
      .rd_ptr_i  (rd_ptr),
      .rd_data_o (hist_rd)
   );

   // A same-cycle shadow write is folded in before the copy so a commit sees it.
   always_comb begin
      shadow_d = shadow_q;
      if (coef_we_i) begin
         shadow_d[coef_addr_i] = coef_data_i;
      end
   end

   assign commit_now = (state_q == IDLE) && (pending_q || coef_commit_i);
   assign pending_d  = commit_now ? 1'b0 : (pending_q || coef_commit_i);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < N; i++) begin
            shadow_q[i] <= CW'(default_coef(i, N));
            active_q[i] <= CW'(default_coef(i, N));
         end
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         if (commit_now) begin
            active_q <= shadow_d;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         ch_q         <= '0;
         sample_q     <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         dout_valid_q <= 1'b0;
         dout_ch_q    <= '0;
         dout_q       <= '0;
         overrun_q    <= 1'b0;
         for (int c = 0; c < CH; c++) begin
            wptr_q[c] <= '0;
         end
      end else begin
         dout_valid_q <= 1'b0;
         if (din_valid_i && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (din_valid_i) begin
                  ch_q     <= din_ch_i;
                  sample_q <= din_i;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               acc_q   <= '0;
               k_q     <= '0;
               state_q <= MAC;
            end
            MAC: begin
               acc_q <= acc_next;
               k_q   <= k_q + NW'(1);
               // Result is registered on the last tap so it is visible throughout OUT.
               if (k_q == K_LAST) begin
                  wptr_q[ch_q] <= wptr_q[ch_q] + NW'(1);
                  dout_q       <= acc_next;
                  dout_ch_q    <= ch_q;
                  dout_valid_q <= 1'b1;
                  state_q      <= OUT;
               end
            end
            OUT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Self-checking bench for fir_tdm_sequencer: randomized and directed samples
// compared against a delay-line FIR model with its own coefficient banks.
module tb_fir_tdm_sequencer;
   import fir_pkg::*;

   localparam int N     = 16;
   localparam int WIDTH = 14;
   localparam int CW    = 16;
   localparam int CH    = 2;
   localparam int OUTW  = 34;
   localparam int NW    = 4;
   localparam int CHW   = 1;

   logic                    clk = 1'b0;
   logic                    n_rst = 1'b0;
   logic                    din_valid_i = 1'b0;
   logic [CHW-1:0]          din_ch_i = '0;
   logic signed [WIDTH-1:0] din_i = '0;
   logic                    din_ready_o;
   logic                    coef_we_i = 1'b0;
   logic [NW-1:0]           coef_addr_i = '0;
   logic signed [CW-1:0]    coef_data_i = '0;
   logic                    coef_commit_i = 1'b0;
   logic                    dout_valid_o;
   logic [CHW-1:0]          dout_ch_o;
   logic signed [OUTW-1:0]  dout_o;
   logic                    busy_o;
   logic                    overrun_o;
   fir_state_t              dbg_state_o;

   always #5 clk = ~clk;

   fir_tdm_sequencer #(
      .N (N), .WIDTH (WIDTH), .CW (CW), .CH (CH), .OUTW (OUTW)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .din_valid_i   (din_valid_i),
      .din_ch_i      (din_ch_i),
      .din_i         (din_i),
      .din_ready_o   (din_ready_o),
      .coef_we_i     (coef_we_i),
      .coef_addr_i   (coef_addr_i),
      .coef_data_i   (coef_data_i),
      .coef_commit_i (coef_commit_i),
      .dout_valid_o  (dout_valid_o),
      .dout_ch_o     (dout_ch_o),
      .dout_o        (dout_o),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o),
      .dbg_state_o   (dbg_state_o)
   );

   int total = 0;
   int bad   = 0;

   logic [OUTW-1:0] exp_q[$];
   int              exp_ch_q[$];

   localparam int DEF_COEF [16] = '{311, 469, 917, 1582, 2352, 3091, 3671, 3990,
                                    3990, 3671, 3091, 2352, 1582, 917, 469, 311};

   // Model: per-channel delay line (index 0 = newest) and two coefficient banks.
   longint hist_m [CH][N];
   longint act_m  [N];
   longint shad_m [N];
   bit     pend_m;

   task automatic model_reset();
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < N; k++) hist_m[c][k] = 0;
      for (int k = 0; k < N; k++) begin
         act_m[k]  = DEF_COEF[k];
         shad_m[k] = DEF_COEF[k];
      end
      pend_m = 1'b0;
   endtask

   function automatic logic [OUTW-1:0] model_push(input int ch, input longint d);
      longint sum;
      for (int k = N - 1; k > 0; k--) hist_m[ch][k] = hist_m[ch][k-1];
      hist_m[ch][0] = d;
      sum = 0;
      for (int k = 0; k < N; k++) sum += hist_m[ch][k] * act_m[k];
      return OUTW'(sum);
   endfunction

   task automatic reset_dut();
      din_valid_i   = 1'b0;
      coef_we_i     = 1'b0;
      coef_commit_i = 1'b0;
      @(negedge clk);
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      model_reset();
   endtask

   task automatic write_coef(input int a, input longint v, input bit commit);
      int w;
      w = 0;
      @(negedge clk);
      while (!din_ready_o && w < 50) begin @(negedge clk); w++; end
      coef_we_i     = 1'b1;
      coef_addr_i   = NW'(a);
      coef_data_i   = CW'(v);
      coef_commit_i = commit;
      shad_m[a] = v;
      if (commit) begin act_m = shad_m; pend_m = 1'b0; end
      @(posedge clk); #1;
      coef_we_i     = 1'b0;
      coef_commit_i = 1'b0;
   endtask

   // side: 0 none, 1 overrun pulse during MAC, 2 shadow write+commit during MAC,
   //       3 reset at tap 5, 4 shadow write+commit in the accept cycle.
   task automatic send(input int ch, input longint d, input int side, input int ca,
                       input longint cv, output logic [OUTW-1:0] got);
      int w;
      int cyc;
      bit seen;
      logic [OUTW-1:0] exp;
      int exp_ch;
      got = '0;
      w = 0;
      @(negedge clk);
      while (!din_ready_o && w < 50) begin @(negedge clk); w++; end
      total++;
      if (din_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL ready_wait: din_ready=%0b required 1", din_ready_o);
      end
      if (pend_m) begin act_m = shad_m; pend_m = 1'b0; end
      din_valid_i = 1'b1;
      din_ch_i    = CHW'(ch);
      din_i       = WIDTH'(d);
      if (side == 4) begin
         coef_we_i = 1'b1; coef_addr_i = NW'(ca); coef_data_i = CW'(cv); coef_commit_i = 1'b1;
         shad_m[ca] = cv; act_m = shad_m; pend_m = 1'b0;
      end
      exp_q.push_back(model_push(ch, d));
      exp_ch_q.push_back(ch);
      @(posedge clk); #1;
      din_valid_i = 1'b0; coef_we_i = 1'b0; coef_commit_i = 1'b0;
      seen = 1'b0;
      for (cyc = 1; cyc <= N + 8; cyc++) begin
         @(negedge clk);
         din_valid_i = 1'b0; coef_we_i = 1'b0; coef_commit_i = 1'b0;
         if (dout_valid_o) begin seen = 1'b1; break; end
         if (cyc == 4 && side == 1) begin
            din_valid_i = 1'b1; din_ch_i = CHW'(ch);
            din_i = WIDTH'($urandom_range(1, 8000));
         end
         if (cyc == 4 && side == 2) begin
            coef_we_i = 1'b1; coef_addr_i = NW'(ca); coef_data_i = CW'(cv); coef_commit_i = 1'b1;
            shad_m[ca] = cv; pend_m = 1'b1;
         end
         if (cyc == 7 && side == 3) begin
            n_rst = 1'b0;
            break;
         end
      end
      exp    = exp_q.pop_front();
      exp_ch = exp_ch_q.pop_front();
      if (side != 3) begin
         total++;
         if (!seen || cyc != N + 2) begin
            bad++;
            $display("FAIL latency: seen=%0b cycle=%0d required cycle %0d", seen, cyc, N + 2);
         end
         total++;
         if (dout_o !== exp) begin
            bad++;
            $display("FAIL dout ch%0d: got %0d required %0d", ch, dout_o, $signed(exp));
         end
         total++;
         if (dout_ch_o !== CHW'(exp_ch)) begin
            bad++;
            $display("FAIL dout_ch: got %0d required %0d", dout_ch_o, exp_ch);
         end
         got = dout_o;
      end
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      total++; if (dout_o !== '0)       begin bad++; $display("FAIL rst_dout: got %0d required 0", dout_o); end
      total++; if (dout_valid_o !== 0)  begin bad++; $display("FAIL rst_dout_valid: got %0b required 0", dout_valid_o); end
      total++; if (dout_ch_o !== '0)    begin bad++; $display("FAIL rst_dout_ch: got %0d required 0", dout_ch_o); end
      total++; if (busy_o !== 0)        begin bad++; $display("FAIL rst_busy: got %0b required 0", busy_o); end
      total++; if (din_ready_o !== 1)   begin bad++; $display("FAIL rst_din_ready: got %0b required 1", din_ready_o); end
      total++; if (overrun_o !== 0)     begin bad++; $display("FAIL rst_overrun: got %0b required 0", overrun_o); end
   endtask

   task automatic test_impulse(input int ch);
      logic [OUTW-1:0] got;
      for (int i = 0; i < N; i++) begin
         send(ch, (i == 0) ? 1 : 0, 0, 0, 0, got);
         total++;
         if (got !== OUTW'(DEF_COEF[i])) begin
            bad++;
            $display("FAIL impulse[%0d]: got %0d required %0d", i, $signed(got), DEF_COEF[i]);
         end
      end
   endtask

   task automatic test_step();
      logic [OUTW-1:0] got;
      longint neg_final;
      neg_final = -268419072;
      for (int i = 0; i < N; i++) send(0, 8191, 0, 0, 0, got);
      total++;
      if (got !== OUTW'(longint'(268386306))) begin
         bad++; $display("FAIL step_pos: got %0d required 268386306", $signed(got));
      end
      for (int i = 0; i < N; i++) send(0, -8192, 0, 0, 0, got);
      total++;
      if (got !== OUTW'(neg_final)) begin
         bad++; $display("FAIL step_neg: got %0d required -268419072", $signed(got));
      end
      total++;
      if (busy_o !== 1'b1) begin
         bad++; $display("FAIL busy_in_out: got %0b required 1", busy_o);
      end
   endtask

   task automatic test_channels();
      logic [OUTW-1:0] got;
      reset_dut();
      for (int i = 0; i < N; i++) begin
         send(0, 8191, 0, 0, 0, got);
         send(1, 0, 0, 0, 0, got);
         total++;
         if (got !== '0) begin bad++; $display("FAIL ch1_zero[%0d]: got %0d required 0", i, $signed(got)); end
      end
      send(0, 8191, 0, 0, 0, got);
      total++;
      if (got !== OUTW'(longint'(268386306))) begin
         bad++; $display("FAIL ch0_final: got %0d required 268386306", $signed(got));
      end
   endtask

   task automatic test_overrun();
      logic [OUTW-1:0] got;
      total++;
      if (overrun_o !== 1'b0) begin bad++; $display("FAIL overrun_pre: got %0b required 0", overrun_o); end
      send(0, 1, 1, 0, 0, got);
      total++;
      if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_set: got %0b required 1", overrun_o); end
      for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0, got);
      total++;
      if (overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %0b required 1", overrun_o); end
   endtask

   task automatic test_coef_commit();
      logic [OUTW-1:0] got;
      send(0, 1, 2, 0, 1000, got);
      send(1, 1, 0, 0, 0, got);
      total++;
      if (got !== OUTW'(longint'(1000))) begin
         bad++; $display("FAIL commit_first_tap: got %0d required 1000", $signed(got));
      end
   endtask

   task automatic test_back_to_back();
      logic [OUTW-1:0] got;
      send(1, 5, 4, 1, -77, got);
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0)
            write_coef($urandom_range(0, N - 1), longint'($urandom_range(0, 65535)) - 32768,
                       $urandom_range(0, 1));
         send($urandom_range(0, CH - 1), longint'($urandom_range(0, 16383)) - 8192, 0, 0, 0, got);
      end
   endtask

   task automatic test_reset_mid();
      logic [OUTW-1:0] got;
      int pulses;
      send(0, 1234, 3, 0, 0, got);
      #1;
      total++; if (dout_o !== '0)      begin bad++; $display("FAIL midrst_dout: got %0d required 0", dout_o); end
      total++; if (busy_o !== 0)       begin bad++; $display("FAIL midrst_busy: got %0b required 0", busy_o); end
      total++; if (overrun_o !== 0)    begin bad++; $display("FAIL midrst_overrun: got %0b required 0", overrun_o); end
      pulses = 0;
      repeat (3) begin @(negedge clk); if (dout_valid_o) pulses++; end
      n_rst = 1'b1;
      model_reset();
      repeat (N + 6) begin @(negedge clk); if (dout_valid_o) pulses++; end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL midrst_no_valid: got %0d pulses required 0", pulses); end
      test_impulse(0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_impulse(0);
      test_step();
      test_channels();
      test_overrun();
      test_coef_commit();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_tdm_sequencer.md
Name: fir_tdm_sequencer

Overview:
Time-multiplexed FIR controller. It shares one signed multiply-accumulate unit across CH input channels and N taps, and replaces the fully parallel N-multiplier filter wherever the ADC sample rate is far below clk. It holds per-channel history in circular buffers, sequences the MAC through all taps, and owns a double-buffered coefficient bank. A register-side write port can update the bank without glitching an in-flight result.

Parameters:
N, 16, filter taps (power of 2)
WIDTH, 14, signed input sample width
CW, 16, signed coefficient width
CH, 2, number of time-shared channels (power of 2, at least 1)
OUTW, WIDTH+CW+$clog2(N), accumulator and output width (34 with defaults)

Ports:
clk  in  1  clock
n_rst  in  1  reset: asynchronous, active-low
din_valid  in  1  sample offered
din_ch  in  $clog2(CH) (min 1)  channel of offered sample
din  in  WIDTH  signed sample
din_ready  out  1  sequencer can accept a sample
coef_we  in  1  write shadow coefficient
coef_addr  in  $clog2(N)  tap index
coef_data  in  CW  signed coefficient
coef_commit  in  1  request shadow-to-active copy
dout_valid  out  1  one-cycle result strobe
dout_ch  out  $clog2(CH) (min 1)  channel of result
dout  out  OUTW  signed filtered result
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: sample offered while not ready

Behaviour:
- Reset state:
  - dout=0, dout_valid=0, dout_ch=0, busy=0, din_ready=1, overrun=0.
  - All history=0, all write pointers=0.
  - Active and shadow banks = default table from package: 311,469,917,1582,2352,3091,3671,3990, mirrored.
- Reset asserted mid-operation: immediate abort, state returns to the reset state, no dout_valid.
- FSM states: IDLE, LOAD, MAC, OUT.
- IDLE:
  - din_ready=1.
  - din_valid=1: latch din_ch and din, go to LOAD.
- LOAD:
  - Write din into hist[ch][wptr[ch]].
  - Clear accumulator, tap counter k=0, go to MAC.
- MAC:
  - One tap per cycle: acc += hist[ch][(wptr[ch]-k) mod N] * coef_active[k], for k=0..N-1.
  - k=0 is the newest sample (the one just written).
  - After k=N-1: increment wptr[ch] mod N, go to OUT.
- OUT:
  - dout<=acc, dout_ch<=ch, dout_valid=1 for exactly this one cycle, go to IDLE.
  - dout holds its value until the next OUT.
- Latency and throughput:
  - Accept edge = cycle 0; dout_valid is high in cycle N+2.
  - The next sample can be accepted in cycle N+3.
  - Peak throughput: one sample per N+3 cycles.
- busy = (state != IDLE).
- Arithmetic:
  - Product is signed WIDTH+CW bits, sign-extended to OUTW.
  - Two's-complement wrap, no saturation; $clog2(N) guard bits make overflow impossible.
- Channels are fully independent: separate history and pointer per channel, shared coefficients.
- overrun: din_valid=1 while din_ready=0 sets overrun, and the sample is dropped. Cleared only by reset.
- Coefficient bank:
  - coef_we writes shadow[coef_addr] in any state.
  - coef_commit sets a pending flag.
  - The copy shadow to active happens on the first cycle the FSM is in IDLE with pending set, then pending clears.
  - The active bank never changes during LOAD, MAC or OUT.
- Simultaneous events:
  - coef_commit and din_valid in the same IDLE cycle: commit takes effect first; the accepted sample uses the new coefficients.
  - coef_we and coef_commit in the same cycle: the write lands in shadow before the copy, so the commit includes it.

Decomposition:
- Package fir_pkg holds:
  - the default coefficient constant array;
  - the state enum typedef (IDLE, LOAD, MAC, OUT);
  - width helper constants.
- Sub-module fir_hist_ram: CH*N x WIDTH history store.
  - Address = {ch, ptr}.
  - One write port and one combinational read port.
  - Reset clears all entries.

Test Plan:
- Impulse: din=1 on ch0, then N-1 zeros on ch0 -> dout sequence 311,469,917,...,469,311, each dout_valid exactly N+2 cycles after its accept.
- Step: 16 samples of 8191 on ch0 -> final dout=268386306. 16 samples of -8192 -> final dout=-268419072.
- Channel isolation: interleave ch0=8191 and ch1=0 for 16 samples each -> all ch1 results 0, ch0 final 268386306, dout_ch correct on every result.
- Overrun: pulse din_valid during MAC -> sample dropped, overrun=1 and stays 1, the next impulse response is unaffected.
- Coefficient commit: write shadow[0]=1000 and commit during MAC -> the in-flight result uses 311; the next impulse produces 1000 at its first output.
- Reset mid-MAC: drop n_rst at k=5 -> dout=0, dout_valid never pulses, history zeroed, a fresh impulse reproduces the default sequence.
